// File: rtl/conv1d_pe_datapath.sv
// Datapath responder for the 1D-convolution PE sequencer: operand memories, MAC
// accumulator and a valid/ready psum output, driven by a CLEAR/MAC/EMIT/DONE command stream.
module conv1d_pe_datapath #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 16,
  parameter int FILTER_LEN = 3,
  parameter int IFMAP_LEN  = 5,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_faddr,
  input  logic [ADDR_W-1:0] cmd_iaddr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_psum,
  output logic [ADDR_W-1:0] out_idx,
  output logic              done,
  output logic              addr_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_MAC   = 2'd1;
  localparam logic [1:0] OP_EMIT  = 2'd2;
  localparam logic [1:0] OP_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] fmem_q [FILTER_LEN];
  logic [DATA_W-1:0] fmem_d [FILTER_LEN];
  logic [DATA_W-1:0] imem_q [IFMAP_LEN];
  logic [DATA_W-1:0] imem_d [IFMAP_LEN];
  logic [DATA_W-1:0] f_q, f_d, x_q, x_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  out_psum_q, out_psum_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;
  logic              addr_err_q, addr_err_d;

  logic                idle_s;
  logic                accept_s;
  logic                wr_ok_s;
  logic                f_hit_s, x_hit_s;
  logic [DATA_W-1:0]   f_rd_s, x_rd_s;
  logic [2*DATA_W-1:0] prod_s;

  assign idle_s    = (state_q == ST_IDLE);
  assign accept_s  = cmd_valid && idle_s;
  assign wr_ok_s   = wr_en && idle_s;
  assign prod_s    = f_q * x_q;

  assign cmd_ready = idle_s;
  assign out_valid = out_valid_q;
  assign out_psum  = out_psum_q;
  assign out_idx   = out_idx_q;
  assign done      = done_q;
  assign addr_err  = addr_err_q;

  // Operand read (out-of-range reads as zero) and load-port memory update
  always_comb begin
    f_rd_s  = '0;
    x_rd_s  = '0;
    f_hit_s = 1'b0;
    x_hit_s = 1'b0;
    for (int i = 0; i < FILTER_LEN; i++) begin
      f_hit_s   = f_hit_s | (cmd_faddr == ADDR_W'(i));
      f_rd_s    = f_rd_s | (fmem_q[i] & {DATA_W{cmd_faddr == ADDR_W'(i)}});
      fmem_d[i] = (wr_ok_s && !wr_sel && (wr_addr == ADDR_W'(i))) ? wr_data : fmem_q[i];
    end
    for (int i = 0; i < IFMAP_LEN; i++) begin
      x_hit_s   = x_hit_s | (cmd_iaddr == ADDR_W'(i));
      x_rd_s    = x_rd_s | (imem_q[i] & {DATA_W{cmd_iaddr == ADDR_W'(i)}});
      imem_d[i] = (wr_ok_s && wr_sel && (wr_addr == ADDR_W'(i))) ? wr_data : imem_q[i];
    end
  end

  // Command decode and IDLE/EXEC/EMIT sequencing
  always_comb begin
    state_d     = state_q;
    f_d         = f_q;
    x_d         = x_q;
    acc_d       = acc_q;
    out_psum_d  = out_psum_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    addr_err_d  = addr_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_CLEAR: acc_d = '0;
            OP_MAC: begin
              // Operands are captured from the pre-write memory contents
              f_d        = f_rd_s;
              x_d        = x_rd_s;
              addr_err_d = addr_err_q | ~f_hit_s | ~x_hit_s;
              state_d    = ST_EXEC;
            end
            OP_EMIT: begin
              out_psum_d  = acc_q;
              out_valid_d = 1'b1;
              state_d     = ST_EMIT;
            end
            OP_DONE: begin
              done_d    = 1'b1;
              out_idx_d = '0;
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        acc_d   = acc_q + ACC_W'(prod_s);
        state_d = ST_IDLE;
      end
      ST_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_idx_d   = out_idx_q + ADDR_W'(1);
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and memory registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      f_q         <= '0;
      x_q         <= '0;
      acc_q       <= '0;
      out_psum_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      for (int i = 0; i < FILTER_LEN; i++) fmem_q[i] <= '0;
      for (int i = 0; i < IFMAP_LEN; i++) imem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      f_q         <= f_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      out_psum_q  <= out_psum_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      addr_err_q  <= addr_err_d;
      fmem_q      <= fmem_d;
      imem_q      <= imem_d;
    end
  end

endmodule

// File: tb/tb_conv1d_pe_datapath.sv
// Self-checking bench for conv1d_pe_datapath: directed sequences, a table of MAC
// vectors and randomized traffic against an arithmetic reference model.
module tb_conv1d_pe_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, wr_sel;
  logic [7:0] wr_addr, wr_data;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_faddr, cmd_iaddr;
  logic       out_valid, out_ready;
  logic [15:0] out_psum;
  logic [7:0] out_idx;
  logic       done, addr_err;

  conv1d_pe_datapath dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_faddr(cmd_faddr), .cmd_iaddr(cmd_iaddr),
    .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum),
    .out_idx(out_idx), .done(done), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain arrays and integer arithmetic
  int fm [3];
  int im [5];
  int acc_m;
  int idx_m;
  int err_m;

  typedef struct {
    logic [7:0]  f;
    logic [7:0]  x;
    int          n;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic load(input logic sel, input int a, input int d);
    wait_idle();
    wr_en = 1'b1; wr_sel = sel; wr_addr = 8'(a); wr_data = 8'(d);
    tick();
    wr_en = 1'b0;
    if (!sel && a < 3) fm[a] = d;
    if (sel && a < 5) im[a] = d;
  endtask

  task automatic send(input logic [1:0] op, input int fa, input int ia);
    wait_idle();
    cmd_valid = 1'b1; cmd_op = op; cmd_faddr = 8'(fa); cmd_iaddr = 8'(ia);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic clear();
    send(2'd0, 0, 0);
    acc_m = 0;
  endtask

  task automatic mac(input int fa, input int ia);
    int fv, xv;
    send(2'd1, fa, ia);
    fv = (fa < 3) ? fm[fa] : 0;
    xv = (ia < 5) ? im[ia] : 0;
    if (fa >= 3 || ia >= 5) err_m = 1;
    acc_m = (acc_m + fv * xv) % 65536;
  endtask

  task automatic emit(input int hold, input logic [15:0] exp);
    send(2'd2, 0, 0);
    check("emit_valid", 32'(out_valid), 32'd1);
    for (int h = 0; h < hold; h++) begin
      check("hold_psum", 32'(out_psum), 32'(exp));
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    check("psum", 32'(out_psum), 32'(exp));
    check("idx", 32'(out_idx), 32'(idx_m));
    tick();
    out_ready = 1'b0;
    check("consumed_valid", 32'(out_valid), 32'd0);
    idx_m = (idx_m + 1) % 256;
  endtask

  task automatic done_cmd();
    send(2'd3, 0, 0);
    check("done_pulse", 32'(done), 32'd1);
    check("done_idx", 32'(out_idx), 32'd0);
    tick();
    check("done_single", 32'(done), 32'd0);
    idx_m = 0;
  endtask

  task automatic conv_pass(input int hold);
    logic [15:0] exp_ps [3];
    exp_ps[0] = 16'd14; exp_ps[1] = 16'd20; exp_ps[2] = 16'd26;
    for (int i = 0; i < 3; i++) begin
      clear();
      for (int j = 0; j < 3; j++) mac(j, i + j);
      emit(hold, exp_ps[i]);
    end
    done_cmd();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd255, 8'd255, 3, 16'd64003};
    vecs[1] = '{8'd1,   8'd1,   1, 16'd1};
    vecs[2] = '{8'd0,   8'd200, 2, 16'd0};
    vecs[3] = '{8'd16,  8'd16,  4, 16'd1024};
    vecs[4] = '{8'd255, 8'd255, 1, 16'd65025};
    vecs[5] = '{8'd128, 8'd2,   5, 16'd1280};
    vecs[6] = '{8'd200, 8'd100, 4, 16'd14464};

    for (int i = 0; i < 3; i++) fm[i] = 0;
    for (int i = 0; i < 5; i++) im[i] = 0;
    acc_m = 0; idx_m = 0; err_m = 0;

    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 8'd0; wr_data = 8'd0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_faddr = 8'd0; cmd_iaddr = 8'd0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_psum", 32'(out_psum), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);

    // Basic convolution, then the same with a back-pressured output
    for (int i = 0; i < 3; i++) load(1'b0, i, i + 1);
    for (int i = 0; i < 5; i++) load(1'b1, i, i + 1);
    conv_pass(0);
    conv_pass(5);

    // Out-of-range load is dropped and does not flag an error
    load(1'b1, 5, 77);
    check("oor_write_no_err", 32'(addr_err), 32'd0);

    // Table of single-address MAC vectors, including accumulator wrap
    for (int v = 0; v < 7; v++) begin
      load(1'b0, 0, int'(vecs[v].f));
      load(1'b1, 0, int'(vecs[v].x));
      clear();
      for (int k = 0; k < vecs[v].n; k++) mac(0, 0);
      emit(v % 2, vecs[v].exp);
    end
    done_cmd();

    // Load and MAC on the same edge: the MAC sees the old ifmap[2]
    for (int i = 0; i < 3; i++) load(1'b0, i, i + 1);
    for (int i = 0; i < 5; i++) load(1'b1, i, i + 1);
    clear();
    wait_idle();
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 8'd2; wr_data = 8'd9;
    mac(0, 2);
    wr_en = 1'b0;
    im[2] = 9;
    mac(0, 2);
    emit(0, 16'd12);

    // Out-of-range filter address contributes zero and sets the sticky flag
    clear();
    mac(0, 0);
    mac(3, 0);
    check("addr_err_set", 32'(addr_err), 32'd1);
    emit(0, 16'd1);
    clear();
    done_cmd();
    check("addr_err_sticky", 32'(addr_err), 32'd1);

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) load(1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) clear();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++)
        mac($urandom_range(0, 3), $urandom_range(0, 5));
      emit($urandom_range(0, 3), 16'(acc_m));
      if ($urandom_range(0, 7) == 0) done_cmd();
    end
    check("rand_addr_err", 32'(addr_err), 32'(err_m));

    // Reset while a psum is waiting in EMIT
    clear();
    mac(0, 0);
    send(2'd2, 0, 0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #2;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_idx", 32'(out_idx), 32'd0);
    check("async_rst_psum", 32'(out_psum), 32'd0);
    check("async_rst_err", 32'(addr_err), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) fm[i] = 0;
    for (int i = 0; i < 5; i++) im[i] = 0;
    acc_m = 0; idx_m = 0; err_m = 0;
    tick();
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    emit(0, 16'd0);
    mac(1, 3);
    mac(2, 4);
    emit(0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
